// File: rtl/ecc_sched_pkg.sv
// Shared encodings for the ECC request scheduler: FSM states and core operation codes.
package ecc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_ENC     = 2'b00;
  localparam logic [1:0] OP_DEC     = 2'b01;
  localparam logic [1:0] OP_FULL    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

endpackage

// File: rtl/ecc_rr_arbiter.sv
// Two-way round-robin arbiter: the pointer names the preferred requester and
// moves to the other one whenever a grant is accepted.
module ecc_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_q;

  always_comb begin
    grant_id = ptr_q;
    if (!valid[ptr_q]) grant_id = ~ptr_q;
    grant = '0;
    if (|valid) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr_q <= 1'b0;
    else if (accept) ptr_q <= ~grant_id;
  end

endmodule

// File: rtl/ecc_request_scheduler.sv
// Shares one ECC controller core between two requesters: round-robin grant, stable core
// command for the whole operation, tagged response. Optional WAIT watchdog: ECC_SCHED_TIMEOUT_EN.
module ecc_request_scheduler
  import ecc_sched_pkg::*;
#(
  parameter int AMBA_WORD      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_ctrl,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [AMBA_WORD-1:0]  req0_width,
  input  logic [DATA_WIDTH-1:0] req0_noise,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_ctrl,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [AMBA_WORD-1:0]  req1_width,
  input  logic [DATA_WIDTH-1:0] req1_noise,
  output logic [AMBA_WORD-1:0]  core_ctrl,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic [AMBA_WORD-1:0]  core_width,
  output logic [AMBA_WORD-1:0]  core_noise,
  output logic                  core_start,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  input  logic                  core_done,
  input  logic [1:0]            core_num_err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_num_err,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef struct packed {
    logic [1:0]            ctrl;
    logic [DATA_WIDTH-1:0] data;
    logic [AMBA_WORD-1:0]  width;
    logic [DATA_WIDTH-1:0] noise;
  } req_t;

  state_e     state_q, state_d;
  req_t       req [2];
  req_t       sel;
  logic [1:0] valid, grant;
  logic       grant_id, accept, illegal, tmo_hit;

  assign req[0]  = {req0_ctrl, req0_data, req0_width, req0_noise};
  assign req[1]  = {req1_ctrl, req1_data, req1_width, req1_noise};
  assign valid   = {req1_valid, req0_valid};
  assign accept  = (state_q == ST_IDLE) && (|valid);
  assign sel     = req[grant_id];
  assign illegal = (sel.ctrl == OP_ILLEGAL);

  ecc_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req0_ready = (state_q == ST_IDLE) && grant[0];
  assign req1_ready = (state_q == ST_IDLE) && grant[1];
  assign core_start = (state_q == ST_ISSUE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);

`ifdef ECC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // tmo_q counts completed WAIT cycles, so the limit fires on the TIMEOUT_CYCLES-th one
  assign tmo_hit = (state_q == ST_WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)                    tmo_q <= '0;
    else if (state_q == ST_ISSUE) tmo_q <= '0;
    else if (state_q == ST_WAIT)  tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (core_done || tmo_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // core_* only change on a legal accept, so the core never sees CTRL move mid-operation
  always_ff @(posedge clk) begin
    if (reset) begin
      core_ctrl    <= '0;
      core_data_in <= '0;
      core_width   <= '0;
      core_noise   <= '0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_num_err  <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          rsp_id <= grant_id;
          if (illegal) begin
            rsp_err     <= 1'b1;
            rsp_data    <= '0;
            rsp_num_err <= '0;
          end else begin
            core_ctrl    <= AMBA_WORD'(sel.ctrl);
            core_data_in <= sel.data;
            core_width   <= sel.width;
            core_noise   <= AMBA_WORD'(sel.noise);
          end
        end
        ST_WAIT: if (core_done) begin
          rsp_data    <= core_data_out;
          rsp_num_err <= (core_ctrl[1:0] == OP_ENC) ? 2'b00 : core_num_err;
          rsp_err     <= 1'b0;
        end else if (tmo_hit) begin
          rsp_data    <= '0;
          rsp_num_err <= '0;
          rsp_err     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_request_scheduler.sv
// Self-checking bench for ecc_request_scheduler: directed scenarios plus a randomized
// run checked against a transaction-level model of requesters, arbiter and core.
module tb_ecc_request_scheduler;
  import ecc_sched_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_ctrl = '0, req1_ctrl = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0, req0_noise = '0, req1_noise = '0;
  logic [AW-1:0] req0_width = '0, req1_width = '0;
  logic [AW-1:0] core_ctrl, core_width, core_noise;
  logic [DW-1:0] core_data_in;
  logic          core_start;
  logic [DW-1:0] core_data_out = '0;
  logic          core_done = 1'b0;
  logic [1:0]    core_num_err = '0;
  logic          rsp_valid, rsp_id, rsp_err, busy;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_num_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ecc_request_scheduler #(.AMBA_WORD(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_data(req0_data), .req0_width(req0_width), .req0_noise(req0_noise),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_data(req1_data), .req1_width(req1_width), .req1_noise(req1_noise),
    .core_ctrl(core_ctrl), .core_data_in(core_data_in), .core_width(core_width),
    .core_noise(core_noise), .core_start(core_start), .core_data_out(core_data_out),
    .core_done(core_done), .core_num_err(core_num_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_num_err(rsp_num_err), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic clear_inputs;
    req0_valid = 0; req1_valid = 0; req0_ctrl = 0; req1_ctrl = 0;
    req0_data = 0; req1_data = 0; req0_width = 0; req1_width = 0;
    req0_noise = 0; req1_noise = 0; core_done = 0; core_data_out = 0;
    core_num_err = 0; rsp_ready = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    req0_data = $urandom; req1_width = $urandom; core_data_out = $urandom; core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready, core_start, rsp_valid, busy, rsp_id, rsp_err, rsp_num_err} !== 9'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0", {req0_ready, req1_ready, core_start, rsp_valid, busy, rsp_id, rsp_err, rsp_num_err});
    end
    total++;
    if ({core_ctrl, core_data_in, core_width, core_noise, rsp_data} !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {core_ctrl, core_data_in, core_width, core_noise, rsp_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    req0_valid = 1; req0_ctrl = OP_ENC; req0_data = 32'h0000_00A5; req0_width = 32'd7; req0_noise = 32'h5;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 0;
    #1;
    total++;
    if ({core_start, core_ctrl, core_data_in, core_width, core_noise} !== {1'b1, 32'd0, 32'hA5, 32'd7, 32'd5}) begin
      bad++; $display("FAIL single_issue: got %b %h %h %h %h", core_start, core_ctrl, core_data_in, core_width, core_noise);
    end
    @(negedge clk); #1;
    total++;
    if ({core_start, busy, rsp_valid} !== 3'b010) begin bad++; $display("FAIL single_wait: got %b want 010", {core_start, busy, rsp_valid}); end
    @(negedge clk);
    @(negedge clk);
    core_done = 1; core_data_out = 32'h1234; core_num_err = 2'b11;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    @(negedge clk);
    core_done = 0; rsp_ready = 1;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data, core_start} !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h1234, 1'b0}) begin
      bad++; $display("FAIL single_rsp: got v=%b id=%b err=%b ne=%b d=%h", rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 0;
    #1;
    total++;
    if ({busy, rsp_valid} !== 2'b00) begin bad++; $display("FAIL single_idle: got %b want 00", {busy, rsp_valid}); end
  endtask

  task automatic test_rr;
    logic exp_id;
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_ctrl = OP_DEC; req1_ctrl = OP_DEC;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      req0_data = 32'h100 + k; req1_data = 32'h200 + k;
      #1;
      total++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_grant%0d: got %b want id %0d", k, {req1_ready, req0_ready}, exp_id);
      end
      @(negedge clk); #1;
      total++;
      if ({core_start, core_data_in, req1_ready, req0_ready} !== {1'b1, (exp_id ? 32'h200 : 32'h100) + k, 2'b00}) begin
        bad++; $display("FAIL rr_issue%0d: got %b %h %b", k, core_start, core_data_in, {req1_ready, req0_ready});
      end
      @(negedge clk);
      core_done = 1; core_data_out = 32'hC0DE_0000 + k; core_num_err = 2'b10;
      @(negedge clk);
      core_done = 0; rsp_ready = 1;
      #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data} !== {1'b1, exp_id, 1'b0, 2'b10, 32'hC0DE_0000 + k}) begin
        bad++; $display("FAIL rr_rsp%0d: got v=%b id=%b err=%b ne=%b d=%h", k, rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data);
      end
      @(negedge clk);
      rsp_ready = 0;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_illegal;
    do_reset();
    req1_valid = 1; req1_ctrl = OP_ILLEGAL; req1_data = $urandom;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL ill_grant: got %b want 10", {req1_ready, req0_ready}); end
    @(negedge clk);
    req1_valid = 0; rsp_ready = 1;
    #1;
    total++;
    if ({core_start, rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data} !== {1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0}) begin
      bad++; $display("FAIL ill_rsp: got st=%b v=%b id=%b err=%b ne=%b d=%h", core_start, rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 0; req0_valid = 1; req1_valid = 1; req0_ctrl = OP_ENC; req1_ctrl = OP_ENC;
    #1;
    total++;
    if ({busy, core_start, req1_ready, req0_ready} !== 4'b0001) begin
      bad++; $display("FAIL ill_after: got %b want 0001", {busy, core_start, req1_ready, req0_ready});
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d;
    d = $urandom;
    do_reset();
    req0_valid = 1; req0_ctrl = OP_FULL; req0_data = $urandom; req0_noise = $urandom;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    core_done = 1; core_data_out = d; core_num_err = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rsp_ready = 0; req0_valid = 1; req1_valid = 1;
      core_done = ~core_done; core_data_out = $urandom; core_num_err = 2'($urandom);
      #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data, req1_ready, req0_ready} !== {1'b1, 1'b0, 1'b0, 2'b01, d, 2'b00}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b id=%b err=%b ne=%b d=%h rdy=%b want d=%h", i, rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data, {req1_ready, req0_ready}, d);
      end
    end
    @(negedge clk);
    rsp_ready = 1; core_done = 0;
    @(negedge clk);
    rsp_ready = 0;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL bp_next_grant: got %b want 10", {req1_ready, req0_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    req0_valid = 1; req0_ctrl = OP_DEC; req0_data = 32'hDEAD_BEEF; req0_width = 32'd3;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    total++;
    if ({req0_ready, req1_ready, core_start, rsp_valid, busy, rsp_id, rsp_err, rsp_num_err, core_ctrl, core_data_in, core_width, core_noise, rsp_data} !== '0) begin
      bad++; $display("FAIL midreset_zero: busy=%b v=%b ctrl=%h din=%h w=%h", busy, rsp_valid, core_ctrl, core_data_in, core_width);
    end
    reset = 0; req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL midreset_ptr: got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
  endtask

`ifdef ECC_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    req0_valid = 1; req0_ctrl = OP_DEC; req0_data = $urandom;
    @(negedge clk);
    req0_valid = 0;
    for (int w = 1; w <= TMO; w++) begin
      @(negedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL tmo_early%0d: got %b want 0", w, rsp_valid); end
    end
    @(negedge clk);
    rsp_ready = 1;
    #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_num_err, rsp_data} !== {1'b1, 1'b1, 2'b00, 32'h0}) begin
      bad++; $display("FAIL tmo_rsp: got v=%b err=%b ne=%b d=%h", rsp_valid, rsp_err, rsp_num_err, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 0; req0_valid = 1;
    @(negedge clk);
    req0_valid = 0;
    for (int w = 1; w < TMO; w++) @(negedge clk);
    @(negedge clk);
    core_done = 1; core_data_out = 32'hFACE_0008; core_num_err = 2'b01;
    @(negedge clk);
    core_done = 0; rsp_ready = 1;
    #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_num_err, rsp_data} !== {1'b1, 1'b0, 2'b01, 32'hFACE_0008}) begin
      bad++; $display("FAIL tmo_done_wins: got v=%b err=%b ne=%b d=%h", rsp_valid, rsp_err, rsp_num_err, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 0;
  endtask
`else
  task automatic test_long_wait;
    do_reset();
    req1_valid = 1; req1_ctrl = OP_FULL; req1_data = $urandom;
    @(negedge clk);
    req1_valid = 0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk); #1;
      total++;
      if ({rsp_valid, busy} !== 2'b01) begin bad++; $display("FAIL long_wait%0d: got %b want 01", w, {rsp_valid, busy}); end
    end
    core_done = 1; core_data_out = 32'h0BAD_F00D; core_num_err = 2'b11;
    @(negedge clk);
    core_done = 0; rsp_ready = 1;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data} !== {1'b1, 1'b1, 1'b0, 2'b11, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL long_rsp: got v=%b id=%b err=%b ne=%b d=%h", rsp_valid, rsp_id, rsp_err, rsp_num_err, rsp_data);
    end
    @(negedge clk);
    rsp_ready = 0;
  endtask
`endif

  // Transaction-level model: one command outstanding at a time, round-robin choice among
  // pending requesters, core answers a random number of cycles after being started.
  task automatic test_random;
    logic          outstanding, start_due, waiting, resp_on, ptr_m, g, g_any;
    logic [1:0]    m_vld, c_ctrl [2];
    logic [DW-1:0] c_data [2], c_noise [2];
    logic [AW-1:0] c_width [2];
    logic [1:0]    t_op, e_ne;
    logic [DW-1:0] t_data, t_noise, e_data;
    logic [AW-1:0] t_width;
    logic          e_id, e_err;
    int            core_wait, ncomp;
    outstanding = 0; start_due = 0; waiting = 0; resp_on = 0; ptr_m = 0;
    m_vld = 0; core_wait = 0; ncomp = 0;
    t_op = 0; t_data = 0; t_noise = 0; t_width = 0; e_id = 0; e_err = 0; e_data = 0; e_ne = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      core_done = 0; core_data_out = $urandom; core_num_err = 2'($urandom);
      if (core_wait > 0) begin
        core_wait--;
        if (core_wait == 0) core_done = 1;
      end
      for (int n = 0; n < 2; n++) begin
        if (!m_vld[n] && $urandom_range(0, 3) == 0) begin
          m_vld[n] = 1; c_ctrl[n] = 2'($urandom); c_data[n] = $urandom;
          c_width[n] = $urandom; c_noise[n] = $urandom;
        end
      end
      req0_valid = m_vld[0]; req0_ctrl = c_ctrl[0]; req0_data = c_data[0]; req0_width = c_width[0]; req0_noise = c_noise[0];
      req1_valid = m_vld[1]; req1_ctrl = c_ctrl[1]; req1_data = c_data[1]; req1_width = c_width[1]; req1_noise = c_noise[1];
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g_any = !outstanding && (|m_vld);
      g     = m_vld[ptr_m] ? ptr_m : !ptr_m;
      total++;
      if ({req1_ready, req0_ready} !== (g_any ? (g ? 2'b10 : 2'b01) : 2'b00)) begin
        bad++; $display("FAIL rnd_ready@%0d: got %b want grant=%b id=%b", cyc, {req1_ready, req0_ready}, g_any, g);
      end
      total++;
      if (rsp_valid !== resp_on) begin bad++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, resp_on); end
      total++;
      if (core_start !== start_due) begin bad++; $display("FAIL rnd_start@%0d: got %b want %b", cyc, core_start, start_due); end
      if (start_due) begin
        total++;
        if ({core_ctrl, core_data_in, core_width, core_noise} !== {32'(t_op), t_data, t_width, t_noise}) begin
          bad++; $display("FAIL rnd_core@%0d: got %h %h %h %h want %h %h %h %h", cyc, core_ctrl, core_data_in, core_width, core_noise, 32'(t_op), t_data, t_width, t_noise);
        end
      end
      if (resp_on) begin
        total++;
        if ({rsp_id, rsp_err, rsp_num_err, rsp_data} !== {e_id, e_err, e_ne, e_data}) begin
          bad++; $display("FAIL rnd_rsp@%0d: got id=%b err=%b ne=%b d=%h want id=%b err=%b ne=%b d=%h", cyc, rsp_id, rsp_err, rsp_num_err, rsp_data, e_id, e_err, e_ne, e_data);
        end
      end
      if (resp_on && rsp_ready) begin resp_on = 0; outstanding = 0; ncomp++; end
      if (waiting && core_done) begin
        waiting = 0; resp_on = 1; e_err = 0; e_data = core_data_out;
        e_ne = (t_op == OP_ENC) ? 2'b00 : core_num_err;
      end
      if (start_due) begin start_due = 0; waiting = 1; core_wait = $urandom_range(1, 6); end
      if (g_any) begin
        outstanding = 1; ptr_m = !g; m_vld[g] = 0; e_id = g;
        if (c_ctrl[g] == OP_ILLEGAL) begin
          resp_on = 1; e_err = 1; e_data = 0; e_ne = 0;
        end else begin
          start_due = 1; t_op = c_ctrl[g]; t_data = c_data[g]; t_width = c_width[g]; t_noise = c_noise[g];
        end
      end
    end
    total++;
    if (ncomp < 50) begin bad++; $display("FAIL rnd_progress: got %0d responses want at least 50", ncomp); end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_illegal();
    test_backpressure();
    test_reset_mid();
`ifdef ECC_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
